// File: rtl/qr_pkg.sv
// Shared types and helpers for the Givens-CORDIC QR datapath.
// Used by the matrix loader and the solver.
package qr_pkg;

   localparam int QR_INT_LEN  = 5;
   localparam int QR_FRAC_LEN = 19;
   localparam int QR_N        = 4;

   localparam logic [QR_INT_LEN+QR_FRAC_LEN-1:0] QR_ONE =
      (QR_INT_LEN+QR_FRAC_LEN)'(1) << QR_FRAC_LEN;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      READY  = 2'd1,
      ISSUE  = 2'd2,
      RESYNC = 2'd3
   } qr_state_t;

   function automatic int elem_w(input int int_len, input int frac_len);
      return int_len + frac_len;
   endfunction

   function automatic int clogb2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/qr_row_buffer.sv
// N-row register file: element-granular write, full-row read.
// Holds one assembled matrix A for the loader.
module qr_row_buffer
   import qr_pkg::*;
#(
   parameter int N  = QR_N,
   parameter int W  = elem_w(QR_INT_LEN, QR_FRAC_LEN),
   parameter int IW = clogb2(QR_N)
) (
   input  logic          clk,
   input  logic          nRst,
   input  logic          wr_en,
   input  logic [IW-1:0] wr_row,
   input  logic [IW-1:0] wr_col,
   input  logic [W-1:0]  wr_data,
   input  logic [IW-1:0] rd_row,
   output logic [N*W-1:0] rd_data
);

   logic [N-1:0][N*W-1:0] mem;

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         mem <= '0;
      end else if (wr_en) begin
         mem[wr_row][wr_col*W +: W] <= wr_data;
      end
   end

   assign rd_data = mem[rd_row];

endmodule

// File: rtl/qr_matrix_loader.sv
// Streams matrix A into a row buffer and issues A rows plus identity
// Q columns to the QR solver, tracking solver occupancy.
module qr_matrix_loader
   import qr_pkg::*;
#(
   parameter int intLenIn   = QR_INT_LEN,
   parameter int fracLenIn  = QR_FRAC_LEN,
   parameter int matrixSize = QR_N,
   localparam int W  = elem_w(intLenIn, fracLenIn),
   localparam int N  = matrixSize,
   localparam int IW = clogb2(matrixSize)
) (
   input  logic          clk,
   input  logic          nRst,
   input  logic          inValid,
   output logic          inReady,
   input  logic [W-1:0]  inData,
   input  logic          inLast,
   input  logic          qrDecompDone,
   output logic          inputValid,
   output logic [N*W-1:0] inputRowR,
   output logic [N*W-1:0] inputColumnQ,
   output logic          solverBusy,
   output logic          frameError
);

   localparam logic [W-1:0]  ONE  = W'(1) << fracLenIn;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   qr_state_t      state_q, state_d;
   logic [IW-1:0]  row_q, row_d;
   logic [IW-1:0]  col_q, col_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic           started_q;
   logic           busy_q, busy_d;
   logic           valid_q, valid_d;
   logic [N*W-1:0] rowr_q, rowr_d;
   logic [N*W-1:0] colq_q, colq_d;
   logic           ferr_q, ferr_d;
   logic           set_busy;
   logic           xfer;
   logic           is_final;
   logic           wr_en;
   logic [IW-1:0]  rd_row;
   logic [N*W-1:0] rd_data;

   function automatic logic [N*W-1:0] ident_col(input logic [IW-1:0] k);
      logic [N*W-1:0] v;
      v = '0;
      for (int c = 0; c < N; c++) begin
         if (IW'(c) == k) v[c*W +: W] = ONE;
      end
      return v;
   endfunction

   qr_row_buffer #(.N(N), .W(W), .IW(IW)) u_buf (
      .clk     (clk),
      .nRst    (nRst),
      .wr_en   (wr_en),
      .wr_row  (row_q),
      .wr_col  (col_q),
      .wr_data (inData),
      .rd_row  (rd_row),
      .rd_data (rd_data)
   );

   assign inReady  = started_q &&
                     (state_q == LOAD || state_q == RESYNC);
   assign xfer     = inValid && inReady;
   assign is_final = (row_q == LAST) && (col_q == LAST);

   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      col_d    = col_q;
      idx_d    = idx_q;
      valid_d  = 1'b0;
      rowr_d   = '0;
      colq_d   = '0;
      ferr_d   = 1'b0;
      set_busy = 1'b0;
      wr_en    = 1'b0;
      rd_row   = '0;
      unique case (state_q)
         LOAD: begin
            if (xfer) begin
               wr_en = 1'b1;
               if (inLast && is_final) begin
                  state_d = READY;
                  row_d   = '0;
                  col_d   = '0;
               end else if (inLast || is_final) begin
                  ferr_d  = 1'b1;
                  row_d   = '0;
                  col_d   = '0;
                  if (is_final) state_d = RESYNC;
               end else if (col_q == LAST) begin
                  col_d = '0;
                  row_d = row_q + IW'(1);
               end else begin
                  col_d = col_q + IW'(1);
               end
            end
         end
         READY: begin
            // a done pulse this cycle frees the solver for the next edge
            if (!busy_q || qrDecompDone) begin
               state_d = ISSUE;
               idx_d   = '0;
               valid_d = 1'b1;
               rowr_d  = rd_data;
               colq_d  = ident_col('0);
            end
         end
         ISSUE: begin
            if (idx_q == LAST) begin
               state_d  = LOAD;
               set_busy = 1'b1;
            end else begin
               idx_d   = idx_q + IW'(1);
               rd_row  = idx_q + IW'(1);
               valid_d = 1'b1;
               rowr_d  = rd_data;
               colq_d  = ident_col(idx_q + IW'(1));
            end
         end
         RESYNC: begin
            if (xfer && inLast) state_d = LOAD;
         end
         default: state_d = LOAD;
      endcase
   end

   assign busy_d = set_busy | (busy_q & ~qrDecompDone);

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q   <= LOAD;
         row_q     <= '0;
         col_q     <= '0;
         idx_q     <= '0;
         started_q <= 1'b0;
         busy_q    <= 1'b0;
         valid_q   <= 1'b0;
         rowr_q    <= '0;
         colq_q    <= '0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         col_q     <= col_d;
         idx_q     <= idx_d;
         started_q <= 1'b1;
         busy_q    <= busy_d;
         valid_q   <= valid_d;
         rowr_q    <= rowr_d;
         colq_q    <= colq_d;
         ferr_q    <= ferr_d;
      end
   end

   assign inputValid   = valid_q;
   assign inputRowR    = rowr_q;
   assign inputColumnQ = colq_q;
   assign solverBusy   = busy_q;
   assign frameError   = ferr_q;

endmodule

// File: tb/tb_qr_matrix_loader.sv
// Directed bench for qr_matrix_loader (N=4, W=24).
module tb_qr_matrix_loader;

   localparam int N = 4;
   localparam int W = 24;
   localparam logic [W-1:0] ONE = 24'h080000;

   logic          clk;
   logic          nRst;
   logic          inValid;
   logic          inReady;
   logic [W-1:0]  inData;
   logic          inLast;
   logic          qrDecompDone;
   logic          inputValid;
   logic [N*W-1:0] inputRowR;
   logic [N*W-1:0] inputColumnQ;
   logic          solverBusy;
   logic          frameError;

   int tests;
   int fails;
   logic [W-1:0] mat [16];

   qr_matrix_loader dut (
      .clk          (clk),
      .nRst         (nRst),
      .inValid      (inValid),
      .inReady      (inReady),
      .inData       (inData),
      .inLast       (inLast),
      .qrDecompDone (qrDecompDone),
      .inputValid   (inputValid),
      .inputRowR    (inputRowR),
      .inputColumnQ (inputColumnQ),
      .solverBusy   (solverBusy),
      .frameError   (frameError)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag,
                        input logic [N*W-1:0] obs,
                        input logic [N*W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [W-1:0] d, input logic l);
      int n;
      n = 0;
      inValid = 1'b1;
      inData  = d;
      inLast  = l;
      while (!inReady && n < 50) begin
         tick();
         n++;
      end
      if (!inReady) check("send_ready_timeout", 0, 1);
      tick();
      inValid = 1'b0;
      inLast  = 1'b0;
   endtask

   task automatic send_frame(input int gaps);
      for (int i = 0; i < 16; i++) begin
         if (gaps != 0) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
               tick();
               if (inputValid) check("gap_no_issue", 1, 0);
            end
         end
         send(mat[i], i == 15);
      end
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!inputValid && n < 40) begin
         tick();
         n++;
      end
      check("issue_timeout", inputValid, 1);
   endtask

   task automatic check_words(input string tag, input int pulse_last);
      logic [N*W-1:0] er;
      logic [N*W-1:0] eq;
      for (int k = 0; k < N; k++) begin
         er = '0;
         eq = '0;
         for (int c = 0; c < N; c++) begin
            er[c*W +: W] = mat[k*N + c];
         end
         eq[k*W +: W] = ONE;
         check({tag, "_valid"}, inputValid, 1);
         check({tag, "_row"}, inputRowR, er);
         check({tag, "_colq"}, inputColumnQ, eq);
         if (k == N - 1 && pulse_last != 0) qrDecompDone = 1'b1;
         tick();
         qrDecompDone = 1'b0;
      end
      check({tag, "_end_valid"}, inputValid, 0);
      check({tag, "_end_row"}, inputRowR, 0);
      check({tag, "_end_busy"}, solverBusy, 1);
   endtask

   task automatic done_pulse();
      qrDecompDone = 1'b1;
      tick();
      qrDecompDone = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      nRst = 1'b0;
      inValid = 1'b0;
      inData = '0;
      inLast = 1'b0;
      qrDecompDone = 1'b0;
      #22;
      check("rst_valid", inputValid, 0);
      check("rst_busy", solverBusy, 0);
      check("rst_ferr", frameError, 0);
      check("rst_row", inputRowR, 0);
      check("rst_colq", inputColumnQ, 0);
      @(negedge clk);
      nRst = 1'b1;
      #1;
      check("rst_first_ready", inReady, 0);
      tick();
      check("ready_load", inReady, 1);

      // 1: basic frame, latency 2
      for (int i = 0; i < 16; i++) mat[i] = W'(i);
      send_frame(0);
      check("t1_ready_state", inReady, 0);
      check("t1_lat0", inputValid, 0);
      tick();
      check("t1_lat1", inputValid, 1);
      check("t1_row0", inputRowR, {24'd3, 24'd2, 24'd1, 24'd0});
      check_words("t1", 0);

      // 2: overlap, second frame waits for done
      for (int i = 0; i < 16; i++) mat[i] = W'(100 + i * 7);
      mat[5] = 24'hFFFFFF;
      send_frame(0);
      for (int i = 0; i < 3; i++) begin
         check("t2_hold_ready", inReady, 0);
         check("t2_hold_valid", inputValid, 0);
         tick();
      end
      done_pulse();
      check("t2_issue_after_done", inputValid, 1);
      check("t2_busy_clr", solverBusy, 0);
      check_words("t2", 0);
      done_pulse();
      check("t2_done_clr", solverBusy, 0);
      done_pulse();
      check("t2_no_underflow", solverBusy, 0);

      // 3: early inLast, then clean frame; done on last word loses to set
      for (int i = 0; i < 6; i++) send(W'(i + 50), 1'b0);
      send(24'd56, 1'b1);
      check("t3_ferr", frameError, 1);
      check("t3_no_issue", inputValid, 0);
      tick();
      check("t3_ferr_pulse", frameError, 0);
      for (int i = 0; i < 16; i++) mat[i] = 24'h800000 | W'(i * 3);
      send_frame(0);
      wait_valid();
      check_words("t3", 1);
      done_pulse();
      check("t3_busy_clr", solverBusy, 0);

      // 4: missing inLast, resync, clean frame
      for (int i = 0; i < 16; i++) send(W'(200 + i), 1'b0);
      check("t4_ferr", frameError, 1);
      send(24'd1, 1'b0);
      check("t4_ferr_pulse", frameError, 0);
      send(24'd2, 1'b0);
      send(24'd3, 1'b1);
      check("t4_resync_no_issue", inputValid, 0);
      check("t4_ferr_quiet", frameError, 0);
      check("t4_back_load", inReady, 1);
      for (int i = 0; i < 16; i++) mat[i] = W'(16 - i) << 8;
      send_frame(0);
      wait_valid();
      check_words("t4", 0);
      done_pulse();

      // 5: gaps inside frame
      for (int i = 0; i < 16; i++) mat[i] = W'(i);
      send_frame(1);
      wait_valid();
      check("t5_row0", inputRowR, {24'd3, 24'd2, 24'd1, 24'd0});
      check_words("t5", 0);
      done_pulse();

      // 6: reset in 2nd issue cycle
      for (int i = 0; i < 16; i++) mat[i] = W'(i + 1000);
      send_frame(0);
      wait_valid();
      tick();
      nRst = 1'b0;
      #1;
      check("t6_rst_valid", inputValid, 0);
      check("t6_rst_busy", solverBusy, 0);
      check("t6_rst_row", inputRowR, 0);
      tick();
      @(negedge clk);
      nRst = 1'b1;
      tick();
      for (int i = 0; i < 16; i++) mat[i] = W'(i * 11 + 5);
      send_frame(0);
      wait_valid();
      check_words("t6", 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
